// File: rtl/tea_stream_controller.sv
// tea_stream_controller
// Valid/ready front-end for the 8-way parallel TEA decryptor array.
// A LATENCY-deep tag pipeline shadows the array so that only real results
// (not bubbles) are captured into a small output FIFO. The array is only
// advanced when the result leaving it has somewhere to go, so nothing is
// ever dropped under downstream backpressure. The key register can only
// change once every issued block has left the array.
module tea_stream_controller #(
    parameter int LATENCY    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_block,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         key_ack,
    output logic         dp_ena,
    output logic [63:0]  dp_in_block,
    output logic [127:0] dp_key,
    input  logic [63:0]  dp_out_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_block,
    output logic [5:0]   inflight,
    output logic         busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};

    // Registered state
    logic [LATENCY-1:0] tag_r;
    logic [5:0]         inflight_r;
    logic               key_pending_r;
    logic               key_ack_r;
    logic [127:0]       dp_key_r;
    logic [63:0]        mem_r [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;

    // Combinational decode
    logic tag_out_s;
    logic pending_s;
    logic any_inflight_s;
    logic fifo_full_s;
    logic fifo_nonempty_s;
    logic pop_s;
    logic stall_s;
    logic adv_s;
    logic accept_s;
    logic retire_s;
    logic key_done_s;

    // Advance, handshake and key-completion decode
    always_comb begin
        tag_out_s       = tag_r[LATENCY-1];
        // A key request seen this cycle already outranks a data request.
        pending_s       = key_pending_r | key_load;
        any_inflight_s  = (inflight_r != 6'd0);
        fifo_full_s     = (count_r == COUNT_FULL);
        fifo_nonempty_s = (count_r != COUNT_ZERO);
        pop_s           = fifo_nonempty_s & out_ready;
        // The slot leaving the array carries real data but the FIFO cannot take it.
        stall_s         = tag_out_s & fifo_full_s & ~pop_s;
        if (pending_s) begin
            // Drain already-issued tags with bubbles, only while no block is offered.
            adv_s = ~in_valid & any_inflight_s & ~stall_s;
        end else begin
            adv_s = (in_valid | any_inflight_s) & ~stall_s;
        end
        accept_s   = adv_s & in_valid & ~pending_s;
        retire_s   = adv_s & tag_out_s;
        key_done_s = pending_s & ~any_inflight_s;
    end

    // Tag pipeline: shifts in lockstep with the array enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r <= {LATENCY{1'b0}};
        end else if (adv_s) begin
            tag_r <= {tag_r[LATENCY-2:0], accept_s};
        end else begin
            tag_r <= tag_r;
        end
    end

    // Count of data tags currently inside the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 6'd0;
        end else begin
            case ({accept_s, retire_s})
                2'b10:   inflight_r <= inflight_r + 6'd1;
                2'b01:   inflight_r <= inflight_r - 6'd1;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Key register: loads only once the array holds no data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_pending_r <= 1'b0;
            key_ack_r     <= 1'b0;
            dp_key_r      <= 128'd0;
        end else begin
            key_ack_r <= key_done_s;
            if (key_done_s) begin
                dp_key_r      <= key_in;
                key_pending_r <= 1'b0;
            end else if (key_load) begin
                key_pending_r <= 1'b1;
            end else begin
                key_pending_r <= key_pending_r;
            end
        end
    end

    // Output FIFO: captures retiring data slots, pops on downstream handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= COUNT_ZERO;
        end else begin
            if (retire_s) begin
                mem_r[wr_ptr_r] <= dp_out_block;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({retire_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready    = adv_s & ~pending_s;
    assign dp_ena      = adv_s;
    assign dp_in_block = in_valid ? in_block : 64'd0;
    assign dp_key      = dp_key_r;
    assign key_ack     = key_ack_r;
    assign out_valid   = fifo_nonempty_s;
    assign out_block   = mem_r[rd_ptr_r];
    assign inflight    = inflight_r;
    assign busy        = any_inflight_s | fifo_nonempty_s;

endmodule

// File: tb/tb_tea_stream_controller.sv
// Directed bench for tea_stream_controller. A behavioural 32-stage array
// model decrypts with the key it sees at entry; plaintexts are encrypted by
// the bench, so every delivered block must equal the original plaintext.
module tb_tea_stream_controller;

    localparam int LAT = 32;
    localparam logic [31:0]  DELTA = 32'h9E3779B9;
    localparam logic [127:0] K1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] K2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_block = 64'd0;
    logic [127:0] key_in = 128'd0;
    logic         key_load = 1'b0;
    logic         key_ack;
    logic         dp_ena;
    logic [63:0]  dp_in_block;
    logic [127:0] dp_key;
    logic [63:0]  dp_out_block;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_block;
    logic [5:0]   inflight;
    logic         busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int ack_cnt = 0;
    int ov_seen = 0;
    int peak = 0;
    bit lat_chk = 1'b0;
    logic [63:0] exp_q[$];
    int acc_q[$];
    int pop_cyc[$];
    logic [63:0] arr [LAT];

    tea_stream_controller #(.LATENCY(LAT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .key_in(key_in), .key_load(key_load),
        .key_ack(key_ack), .dp_ena(dp_ena), .dp_in_block(dp_in_block),
        .dp_key(dp_key), .dp_out_block(dp_out_block), .out_valid(out_valid),
        .out_ready(out_ready), .out_block(out_block), .inflight(inflight),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tea_enc(input logic [63:0] b, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = b[63:32]; v1 = b[31:0]; s = 32'd0;
        for (int r = 0; r < 32; r++) begin
            s  = s + DELTA;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [63:0] b, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = b[63:32]; v1 = b[31:0]; s = 32'hC6EF3720;
        for (int r = 0; r < 32; r++) begin
            v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
            v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            s  = s - DELTA;
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] pt(input int i);
        return {32'h1000_0000 + 32'(i), 32'hCAFE_0000 ^ 32'(i)};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Array model: decrypt on entry, then a LAT-stage delay enabled by dp_ena
    initial for (int i = 0; i < LAT; i++) arr[i] = 64'd0;
    always @(posedge clk) begin
        if (dp_ena) begin
            for (int i = LAT - 1; i > 0; i--) arr[i] <= arr[i-1];
            arr[0] <= tea_dec(dp_in_block, dp_key);
        end
    end
    assign dp_out_block = arr[LAT-1];

    always @(posedge clk) cyc++;

    // Monitor: scoreboard on output handshakes, mid-cycle sampling
    always @(negedge clk) begin
        if (key_ack) ack_cnt++;
        if (out_valid) ov_seen++;
        if (int'(inflight) > peak) peak = int'(inflight);
        if (out_valid && out_ready) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 128'(out_block), 128'(64'd0) + 128'(exp_q.size()));
            end else begin
                check_val("out_block", 128'(out_block), 128'(exp_q.pop_front()));
                if (lat_chk && acc_q.size() != 0)
                    check_val("latency", 128'(cyc - acc_q.pop_front()), 128'(33));
            end
        end
    end

    task automatic send(input int i, input logic [127:0] k);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_block = tea_enc(pt(i), k);
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("send_wait", 128'(n), 128'(0));
        end else begin
            exp_q.push_back(pt(i));
            if (lat_chk) acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_block = 64'd0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        int n;
        for (n = 0; n < 400 && exp_q.size() != 0; n++) begin @(posedge clk); #1; end
        check_val(tag, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        check_val("key_ack_pulse", 128'(key_ack), 128'(1));
        check_val("dp_key_loaded", dp_key, k);
        @(posedge clk); #1;
        check_val("key_ack_low", 128'(key_ack), 128'(0));
    endtask

    initial begin
        int p0, a0, ok, n;
        bit seen_ready, found;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, a0, ok, n;
        bit seen_ready, found;
        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 128'(in_ready), 128'(0));
        check_val("rst_dp_ena", 128'(dp_ena), 128'(0));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_inflight", 128'(inflight), 128'(0));
        check_val("rst_dp_key", dp_key, 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("idle_dp_ena", 128'(dp_ena), 128'(0));
        check_val("idle_busy", 128'(busy), 128'(0));
        load_key(K1);

        // ---- T1: 8 back-to-back blocks, exact 33-cycle latency
        out_ready = 1'b1;
        lat_chk = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) send(i, K1);
        check_val("t1_inflight", 128'(inflight), 128'(8));
        check_val("t1_busy", 128'(busy), 128'(1));
        drain("t1_drain");
        check_val("t1_pops", 128'(pop_cnt - p0), 128'(8));
        lat_chk = 1'b0;
        idle(2);

        // ---- T2: backpressure with 10 blocks
        out_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 10; i < 20; i++) send(i, K1);
        idle(40);
        check_val("t2_inflight", 128'(inflight), 128'(6));
        check_val("t2_dp_ena", 128'(dp_ena), 128'(0));
        check_val("t2_out_valid", 128'(out_valid), 128'(1));
        in_valid = 1'b1;
        in_block = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        check_val("t2_in_ready_full", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        in_block = 64'd0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("t2_drain");
        check_val("t2_pops", 128'(pop_cnt - p0), 128'(10));
        idle(2);

        // ---- T3: 1,0,1,0 input gaps
        peak = 0;
        pop_cyc.delete();
        send(30, K1);
        @(negedge clk);
        check_val("t3_gap_ena0", 128'(dp_ena), 128'(1));
        @(posedge clk); #1;
        send(31, K1);
        @(negedge clk);
        check_val("t3_gap_ena1", 128'(dp_ena), 128'(1));
        @(posedge clk); #1;
        drain("t3_drain");
        check_val("t3_peak", 128'(peak), 128'(2));
        check_val("t3_npop", 128'(pop_cyc.size()), 128'(2));
        if (pop_cyc.size() == 2)
            check_val("t3_out_gap", 128'(pop_cyc[1] - pop_cyc[0]), 128'(2));
        idle(2);

        // ---- T4: key change with 5 blocks in flight
        for (int i = 40; i < 45; i++) send(i, K1);
        key_in = K2;
        key_load = 1'b1;
        in_valid = 1'b1;
        in_block = tea_enc(pt(45), K2);
        @(negedge clk);
        check_val("t4_key_prio_ready", 128'(in_ready), 128'(0));
        check_val("t4_key_prio_ena", 128'(dp_ena), 128'(0));
        @(posedge clk); #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        in_block = 64'd0;
        a0 = ack_cnt;
        seen_ready = 1'b0;
        found = 1'b0;
        for (n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (in_ready) seen_ready = 1'b1;
            if (key_ack) found = 1'b1;
        end
        check_val("t4_ack_seen", 128'(found), 128'(1));
        check_val("t4_ready_while_pending", 128'(seen_ready), 128'(0));
        check_val("t4_inflight_at_ack", 128'(inflight), 128'(0));
        check_val("t4_dp_key", dp_key, K2);
        idle(3);
        check_val("t4_ack_once", 128'(ack_cnt - a0), 128'(1));
        send(45, K2);
        send(46, K2);
        drain("t4_drain");
        idle(2);

        // ---- T5: async reset with 3 in flight and 2 in the FIFO
        out_ready = 1'b0;
        for (int i = 50; i < 55; i++) send(i, K2);
        found = 1'b0;
        for (n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (inflight == 6'd3 && out_valid) found = 1'b1;
        end
        check_val("t5_setup", 128'(found), 128'(1));
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_val("t5_out_valid", 128'(out_valid), 128'(0));
        check_val("t5_out_block", 128'(out_block), 128'(0));
        check_val("t5_inflight", 128'(inflight), 128'(0));
        check_val("t5_busy", 128'(busy), 128'(0));
        check_val("t5_dp_key", dp_key, 128'(0));
        check_val("t5_dp_ena", 128'(dp_ena), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ov_seen = 0;
        idle(50);
        check_val("t5_no_stale_out", 128'(ov_seen), 128'(0));

        // ---- T6: full FIFO with simultaneous push and pop
        load_key(K1);
        out_ready = 1'b0;
        for (int i = 60; i < 90; i++) send(i, K1);
        idle(20);
        check_val("t6_stalled_inflight", 128'(inflight), 128'(26));
        out_ready = 1'b1;
        p0 = pop_cnt;
        ok = 0;
        repeat (20) begin
            @(negedge clk);
            if (dp_ena && out_valid) ok++;
        end
        @(posedge clk); #1;
        check_val("t6_ena_every_cycle", 128'(ok), 128'(20));
        check_val("t6_throughput", 128'(pop_cnt - p0), 128'(20));
        check_val("t6_inflight_after", 128'(inflight), 128'(6));
        drain("t6_drain");
        check_val("t6_total_pops", 128'(pop_cnt - p0), 128'(30));
        idle(3);
        check_val("end_busy", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
